// File: rtl/plot_framebuffer.sv
// Pixel-write sink: stores plot/x/y/colour writes in a COLS x ROWS x 3-bit buffer and
// raster-scans it out continuously with blanking/sync flags; clears itself on reset or request.
module plot_framebuffer #(
    parameter int         XW        = 2,
    parameter int         YW        = 2,
    parameter int         COLS      = 4,
    parameter int         ROWS      = 4,
    parameter int         HBLANK    = 2,
    parameter int         VBLANK    = 1,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          plot,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [2:0]    colour,
    input  logic          clear,
    output logic          busy,
    output logic          err_oob,
    output logic          dropped,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [2:0]    pix_colour,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int NPIX = COLS * ROWS;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int HTOT = COLS + HBLANK;
    localparam int VTOT = ROWS + VBLANK;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_sweep_addr;
    logic [2:0]    r_mem [NPIX];
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_err_oob;
    logic          r_dropped;
    logic          r_pix_valid;
    logic [XW-1:0] r_pix_x;
    logic [YW-1:0] r_pix_y;
    logic [2:0]    r_pix_colour;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_frame_start;

    logic          w_busy;
    logic          w_in_range;
    logic [AW-1:0] w_plot_addr;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [2:0]    w_wdata;
    logic          w_active;
    logic [AW-1:0] w_raddr;
    logic [2:0]    w_rdata;
    logic          w_h_last;
    logic          w_v_last;

    assign w_busy      = (r_state == S_SWEEP);
    assign w_in_range  = (int'(x) < COLS) && (int'(y) < ROWS);
    assign w_plot_addr = AW'(int'(y) * COLS + int'(x));

    // Single write port: the sweep owns it while busy, otherwise an in-range plot.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_sweep_addr;
        w_wdata = BG_COLOUR;
        if (!reset) begin
            if (w_busy) begin
                w_we = 1'b1;
            end else if (plot && w_in_range) begin
                w_we    = 1'b1;
                w_waddr = w_plot_addr;
                w_wdata = colour;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_SWEEP;
            r_sweep_addr <= '0;
        end else if (r_state == S_IDLE) begin
            if (clear) begin
                r_state      <= S_SWEEP;
                r_sweep_addr <= '0;
            end
        end else begin
            if (r_sweep_addr == AW'(NPIX - 1))
                r_state <= S_IDLE;
            r_sweep_addr <= r_sweep_addr + AW'(1);
        end
    end

    // A plot refused for being busy is reported as dropped, not as out of range.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_oob <= 1'b0;
            r_dropped <= 1'b0;
        end else if (plot) begin
            if (w_busy)
                r_dropped <= 1'b1;
            else if (!w_in_range)
                r_err_oob <= 1'b1;
        end
    end

    assign w_h_last = (r_h == HW'(HTOT - 1));
    assign w_v_last = (r_v == VW'(VTOT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    assign w_active = (int'(r_h) < COLS) && (int'(r_v) < ROWS);
    assign w_raddr  = AW'(int'(r_v) * COLS + int'(r_h));
    // Write-through: a same-cycle write to the scanned address is shown immediately.
    assign w_rdata  = (w_we && (w_waddr == w_raddr)) ? w_wdata : r_mem[w_raddr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_colour  <= 3'b000;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_valid   <= w_active;
            r_pix_x       <= w_active ? XW'(r_h) : '0;
            r_pix_y       <= w_active ? YW'(r_v) : '0;
            r_pix_colour  <= w_active ? w_rdata : 3'b000;
            r_hsync       <= (int'(r_h) >= COLS);
            r_vsync       <= (int'(r_v) >= ROWS);
            r_frame_start <= (r_h == '0) && (r_v == '0);
        end
    end

    assign busy        = w_busy;
    assign err_oob     = r_err_oob;
    assign dropped     = r_dropped;
    assign pix_valid   = r_pix_valid;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_colour  = r_pix_colour;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule
